// File: rtl/blackbox_sweeper.sv
// Sweeps a combinational blackbox through every input vector and captures its truth table.
// Optional golden-table compare is built when BLACKBOX_SWEEP_CHECK_EN is defined.
module blackbox_sweeper #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out
`ifdef BLACKBOX_SWEEP_CHECK_EN
    ,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic                   mismatch
`endif
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t          state, state_nxt;
    logic [N_IN-1:0] index;
    logic [3:0]      settle_cnt;
    logic            accept;
    logic            sample;
    logic            last_vec;

    assign last_vec = &index;
    assign dut_in   = index;
    assign busy     = (state == DRIVE);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_cnt == 4'd0) begin
                    sample = 1'b1;
                    if (last_vec) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Each vector is held SETTLE+1 cycles; the capture happens on the last one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            index      <= '0;
            settle_cnt <= 4'd0;
            table_out  <= '0;
        end else if (accept) begin
            index      <= '0;
            settle_cnt <= 4'(SETTLE);
            table_out  <= '0;
        end else if (state == DRIVE) begin
            if (settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end else begin
                table_out[index] <= dut_out;
                if (!last_vec) begin
                    index      <= index + 1'b1;
                    settle_cnt <= 4'(SETTLE);
                end
            end
        end else if (state == DONE) begin
            index <= '0;
        end
    end

`ifdef BLACKBOX_SWEEP_CHECK_EN
    logic [(1<<N_IN)-1:0] expected_q;
    logic [(1<<N_IN)-1:0] table_final;

    // The last bit lands in table_out on the same edge, so compare against the merged value.
    always_comb begin
        table_final        = table_out;
        table_final[index] = dut_out;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            expected_q <= '0;
            mismatch   <= 1'b0;
        end else if (accept) begin
            expected_q <= expected;
            mismatch   <= 1'b0;
        end else if (sample && last_vec) begin
            mismatch <= (table_final != expected_q);
        end
    end
`endif

endmodule

// File: tb/tb_blackbox_sweeper.sv
// Directed bench for blackbox_sweeper: majority DUT (SETTLE=1) and XOR DUT (SETTLE=0),
// with a scoreboard of expected tables popped on each done pulse.
module tb_blackbox_sweeper;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_m, start_x;
    logic [2:0] din_m, din_x;
    logic       out_m, out_x;
    logic       busy_m, busy_x, done_m, done_x;
    logic [7:0] tab_m, tab_x;
`ifdef BLACKBOX_SWEEP_CHECK_EN
    logic [7:0] exp_m, exp_x;
    logic       mis_m, mis_x;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb_m[$];
    logic [7:0] sb_x[$];

    always #5 clk = ~clk;

    // Blackboxes under sweep
    assign out_m = (din_m[2] & din_m[1]) | (din_m[2] & din_m[0]) | (din_m[1] & din_m[0]);
    assign out_x = ^din_x;

    blackbox_sweeper #(.N_IN(3), .SETTLE(1)) u_maj (
        .clk(clk), .reset(reset), .start(start_m), .dut_in(din_m), .dut_out(out_m),
        .busy(busy_m), .done(done_m), .table_out(tab_m)
`ifdef BLACKBOX_SWEEP_CHECK_EN
        , .expected(exp_m), .mismatch(mis_m)
`endif
    );

    blackbox_sweeper #(.N_IN(3), .SETTLE(0)) u_xor (
        .clk(clk), .reset(reset), .start(start_x), .dut_in(din_x), .dut_out(out_x),
        .busy(busy_x), .done(done_x), .table_out(tab_x)
`ifdef BLACKBOX_SWEEP_CHECK_EN
        , .expected(exp_x), .mismatch(mis_x)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each done pulse must match the oldest pending expected table.
    always @(negedge clk) begin
        if (reset === 1'b1 && done_m === 1'b1) begin
            check("sb_m_pending", 32'(sb_m.size() > 0), 1);
            if (sb_m.size() > 0) check("sb_m_table", tab_m, sb_m.pop_front());
        end
        if (reset === 1'b1 && done_x === 1'b1) begin
            check("sb_x_pending", 32'(sb_x.size() > 0), 1);
            if (sb_x.size() > 0) check("sb_x_table", tab_x, sb_x.pop_front());
        end
    end

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_m = v;
        else          start_x = v;
    endtask

    // Called right after a negedge. Drives start, then checks every cycle against a
    // cycle model: sweep period = 8*hold busy cycles + done + one idle/accept cycle.
    task automatic sweep(input string tag, input int sel, input int hold, input bit b2b,
                         input int total, input int p1, input int p2,
                         input logic [7:0] exp_tab, input int exp_nd);
        int period, m, nd, first, second, errs;
        logic eb, ed, ob, od;
        logic [2:0] edin, odin;
        logic [7:0] otab;
        period = 8 * hold + 2;
        nd = 0; first = 0; second = 0; errs = 0;
        set_start(sel, 1'b1);
        for (int n = 1; n <= total; n++) begin
            @(negedge clk);
            if (b2b || n <= period) m = (n - 1) % period;
            else                    m = period - 1;
            eb   = (m < 8 * hold);
            ed   = (m == 8 * hold);
            edin = eb ? 3'(m / hold) : (ed ? 3'd7 : 3'd0);
            ob   = (sel == 0) ? busy_m : busy_x;
            od   = (sel == 0) ? done_m : done_x;
            odin = (sel == 0) ? din_m  : din_x;
            otab = (sel == 0) ? tab_m  : tab_x;
            if (ob !== eb || od !== ed || odin !== edin) errs++;
            if (!eb && n > 8 * hold && otab !== exp_tab) errs++;
            if (od === 1'b1) begin
                nd++;
                if (nd == 1) first = n;
                if (nd == 2) second = n;
            end
            set_start(sel, b2b || n == p1 || n == p2);
        end
        set_start(sel, 1'b0);
        check({tag, "_cycle_errs"}, errs, 0);
        check({tag, "_done_count"}, nd, exp_nd);
        check({tag, "_done_first"}, first, 8 * hold + 1);
        if (exp_nd > 1) check({tag, "_done_second"}, second, period + 8 * hold + 1);
    endtask

    task automatic wait_idle(input string tag, input int sel);
        int n;
        n = 0;
        while (n < 60 && (((sel == 0) ? (busy_m | done_m) : (busy_x | done_x)) !== 1'b0)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_reached"}, 32'(n < 60), 1);
    endtask

    initial begin
        reset = 1'b0; start_m = 1'b0; start_x = 1'b0;
`ifdef BLACKBOX_SWEEP_CHECK_EN
        exp_m = 8'h00; exp_x = 8'h00;
`endif
        repeat (3) @(negedge clk);
        check("rst_maj", {busy_m, done_m, din_m, tab_m}, 0);
        check("rst_xor", {busy_x, done_x, din_x, tab_x}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Reset mid-sweep on the XOR sweeper: bits 1,2 captured by cycle 5
        start_x = 1'b1;
        @(negedge clk);
        start_x = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_partial_table", tab_x, 8'b0000_0110);
        check("mid_busy_before", busy_x, 1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_state", {busy_x, done_x, din_x, tab_x}, 0);
        reset = 1'b1;
        @(negedge clk);

        sb_x.push_back(8'b1001_0110);
        sweep("xor", 1, 1, 1'b0, 14, -1, -1, 8'b1001_0110, 1);

        sb_m.push_back(8'b1110_1000);
        sweep("maj", 0, 2, 1'b0, 24, -1, -1, 8'b1110_1000, 1);

        sb_m.push_back(8'b1110_1000);
        sweep("maj_ignore", 0, 2, 1'b0, 24, 3, 10, 8'b1110_1000, 1);

        // Held start runs into a third sweep that the scoreboard also expects
        repeat (3) sb_m.push_back(8'b1110_1000);
        sweep("maj_b2b", 0, 2, 1'b1, 40, -1, -1, 8'b1110_1000, 2);
        wait_idle("maj_b2b", 0);
        @(negedge clk);
        check("maj_b2b_final_table", tab_m, 8'b1110_1000);

`ifdef BLACKBOX_SWEEP_CHECK_EN
        exp_m = 8'b1110_1000;
        sb_m.push_back(8'b1110_1000);
        sweep("chk_good", 0, 2, 1'b0, 20, -1, -1, 8'b1110_1000, 1);
        check("chk_good_mismatch", mis_m, 0);
        exp_m = 8'b1110_1001;
        sb_m.push_back(8'b1110_1000);
        sweep("chk_bad", 0, 2, 1'b0, 20, -1, -1, 8'b1110_1000, 1);
        check("chk_bad_mismatch", mis_m, 1);
        repeat (5) @(negedge clk);
        check("chk_bad_mismatch_hold", mis_m, 1);
`endif

        check("sb_m_empty", sb_m.size(), 0);
        check("sb_x_empty", sb_x.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blackbox_sweeper.md
Name: blackbox_sweeper

Overview:
- Sequencer that exhaustively drives the 3-input combinational blackbox through all input vectors and captures its output into a truth-table register.
- Sits beside the blackbox instance; replaces hand-written stimulus sequences with a start/done-controlled sweep that a higher-level controller or bench can trigger.
- One sweep produces a 2^N_IN-bit table; bit i holds the DUT output for input vector i.

Parameters:
- N_IN, 3, number of DUT inputs; the sweep covers 2^N_IN vectors; legal range 1..6.
- SETTLE, 1, extra hold cycles per vector before sampling; legal range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  request a sweep; accepted only in IDLE.
- dut_in  output  N_IN  vector driven to the blackbox; dut_in[N_IN-1] maps to a_in, dut_in[0] maps to c_in.
- dut_out  input  1  blackbox output (h_out).
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the table is complete.
- table_out  output  2^N_IN  captured truth table; bit i = dut_out observed while dut_in == i.

Behaviour:
- Reset (reset == 0 at a clk edge): state IDLE; dut_in = 0, busy = 0, done = 0, table_out = 0, index = 0, settle counter = 0. Reset takes priority over all other inputs, including mid-sweep; the partial table is discarded.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - If start == 1 at an edge: go to DRIVE, clear table_out to 0, index = 0, dut_in = 0, settle counter = SETTLE, busy = 1.
  - Otherwise hold. dut_in holds 0.
- DRIVE (per vector):
  - While the settle counter != 0 at an edge: decrement it.
  - When the settle counter == 0 at an edge: table_out[index] <= dut_out.
    - If index == 2^N_IN - 1: go to DONE, busy = 0, done = 1.
    - Otherwise: index++, dut_in = index + 1, reload the counter with SETTLE.
  - Each vector is held exactly SETTLE+1 cycles and sampled on its last cycle.
- DONE: lasts one cycle with done = 1, then goes to IDLE with done = 0. dut_in returns to 0 on entering IDLE.
- Latency: if start is accepted at edge k, busy is high for cycles k+1 .. k+2^N_IN*(SETTLE+1), and done is high for exactly the following cycle. Example with defaults: busy for 16 cycles, done on cycle 17.
- table_out holds its value from DONE until the next accepted start or reset. It never changes while in IDLE.
- start asserted while in DRIVE or DONE is ignored; it is not queued.
- start held high continuously: a new sweep begins on the edge where the FSM is in IDLE, i.e. the cycle after done.
- Index width: N_IN bits. The final vector (all ones) terminates the sweep; no wrap past 2^N_IN - 1 is ever driven.
- SETTLE = 0: one cycle per vector; with the default N_IN the sweep is 8 cycles.

Optional Feature:
- Macro: BLACKBOX_SWEEP_CHECK_EN.
- Defined:
  - Adds input expected (2^N_IN bits), sampled into an internal register on the start-accept edge.
  - Adds output mismatch (1 bit), reset to 0 and cleared on start-accept.
  - On the DRIVE-to-DONE edge, mismatch <= (final table != captured expected). The flag is valid from the done cycle and holds until the next start or reset.
- Undefined: neither port exists and no compare logic is built. All other behaviour is identical.

Test Plan:
- Reset mid-sweep: start, then reset = 0 at cycle 5 -> next cycle busy = 0, done = 0, dut_in = 0, table_out = 0; a new start afterwards completes normally.
- Majority-function DUT, defaults (N_IN = 3, SETTLE = 1): one start pulse -> dut_in steps 0..7, each held 2 cycles; busy high 16 cycles; done pulses once on cycle 17; table_out = 8'b11101000.
- XOR DUT, SETTLE = 0: start -> done on cycle 9; table_out = 8'b10010110; dut_in holds each value exactly 1 cycle.
- start pulsed again at cycles 3 and 10 during a sweep -> ignored: exactly one done pulse; table_out unchanged from the single-sweep result.
- start held high for 40 cycles, majority DUT, defaults -> back-to-back sweeps; done at cycles 17 and 35; table_out stays 8'b11101000 after each done.
- Macro defined, majority DUT: expected = 8'b11101000 -> mismatch = 0 at done; expected = 8'b11101001 -> mismatch = 1 at done and held until the next start.
